// File: rtl/lite_arb_pkg.sv
// Shared FSM encodings, grant-width helper and DMA register offsets for the
// lite config-write arbiter and its benches.
package lite_arb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_DONE  = 4'b1000
  } state_t;

  localparam int unsigned REG_DMACR  = 32'h30;
  localparam int unsigned REG_DMASR  = 32'h34;
  localparam int unsigned REG_DA     = 32'h48;
  localparam int unsigned REG_MSB    = 32'h4C;
  localparam int unsigned REG_LENGTH = 32'h58;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned grant_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lite_cfg_arbiter_rr_pick.sv
// Round-robin selector: first pending index strictly after the last grant,
// wrapping around.
module rr_pick
  import lite_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 2,
  localparam int unsigned GW    = grant_w(N_REQ)
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [GW-1:0]    last,
  output logic [GW-1:0]    idx,
  output logic             any
);

  localparam int unsigned CW = GW + 1;

  logic [CW-1:0] cand;
  logic          found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = CW'(last) + CW'(k);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (!found && pending[cand[GW-1:0]]) begin
        idx   = cand[GW-1:0];
        found = 1'b1;
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/lite_cfg_arbiter.sv
// Shares one AXI-Lite register-write master between N_REQ requesters, one write
// outstanding at a time. Define LITE_ARB_TIMEOUT_EN to bound the WAIT state.
module lite_cfg_arbiter
  import lite_arb_pkg::*;
#(
  parameter  int unsigned N_REQ          = 2,
  parameter  int unsigned ADDR_W         = 10,
  parameter  int unsigned DATA_W         = 32,
  parameter  int unsigned TIMEOUT_CYCLES = 1023,
  localparam int unsigned GW             = grant_w(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_awaddr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_end,
  output logic [N_REQ-1:0]          req_pending,
  output logic [N_REQ-1:0]          req_ovf,
  output logic [ADDR_W-1:0]         m_awaddr,
  output logic [DATA_W-1:0]         m_wdata,
  output logic                      m_valid,
  input  logic                      m_end,
  output logic [GW-1:0]             grant_id,
  output logic                      timeout_err
);

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  clear_c, capture_c, ovf_c;
  logic [GW-1:0]     last_q, pick_idx;
  logic              pick_any;
  logic [ADDR_W-1:0] slot_addr [N_REQ];
  logic [DATA_W-1:0] slot_data [N_REQ];

`ifdef LITE_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit_c;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .pending (req_pending),
    .last    (last_q),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  // Completion clears the slot, but a coincident new request wins.
  always_comb begin
    clear_c = '0;
    if (state_q == ST_DONE) clear_c[grant_id] = 1'b1;
    capture_c = req_valid & (~req_pending | clear_c);
    ovf_c     = req_valid & req_pending & ~clear_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
`ifdef LITE_ARB_TIMEOUT_EN
    tmo_hit_c = 1'b0;
`endif
    case (state_q)
      ST_IDLE:  if (pick_any) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (m_end) state_d = ST_DONE;
`ifdef LITE_ARB_TIMEOUT_EN
        else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_DONE;
          tmo_hit_c = 1'b1;
        end
`endif
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Slots, sticky flags and the registered master/requester interface.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_pending <= '0;
      req_ovf     <= '0;
      req_end     <= '0;
      m_valid     <= 1'b0;
      m_awaddr    <= '0;
      m_wdata     <= '0;
      grant_id    <= '0;
      last_q      <= GW'(N_REQ - 1);
      for (int unsigned i = 0; i < N_REQ; i++) begin
        slot_addr[i] <= '0;
        slot_data[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (capture_c[i]) begin
          slot_addr[i] <= req_awaddr[i*ADDR_W +: ADDR_W];
          slot_data[i] <= req_wdata[i*DATA_W +: DATA_W];
        end
      end
      req_pending <= (req_pending & ~clear_c) | capture_c;
      req_ovf     <= req_ovf | ovf_c;
      m_valid     <= (state_d == ST_ISSUE);
      req_end     <= (state_d == ST_DONE) ? (N_REQ'(1) << grant_id) : '0;
      if (state_q == ST_IDLE && pick_any) begin
        grant_id <= pick_idx;
        m_awaddr <= slot_addr[pick_idx];
        m_wdata  <= slot_data[pick_idx];
      end
      if (state_q == ST_DONE) last_q <= grant_id;
    end
  end

`ifdef LITE_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE)     tmo_cnt <= '0;
      else if (state_q == ST_WAIT) tmo_cnt <= tmo_cnt + TW'(1);
      if (tmo_hit_c) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_lite_cfg_arbiter.sv
// Self-checking bench for lite_cfg_arbiter: vector table, scoreboard of master
// writes and completions, plus hand-timed latency/reset/timeout sequences.
module tb_lite_cfg_arbiter;
  import lite_arb_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_awaddr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_end, req_pending, req_ovf;
  logic [AW-1:0]   m_awaddr;
  logic [DW-1:0]   m_wdata;
  logic            m_valid, m_end, timeout_err;
  logic [0:0]      grant_id;
  logic            man_end, resp_end;

  always #5 clk = ~clk;
  assign m_end = man_end | resp_end;

  lite_cfg_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_awaddr(req_awaddr),
    .req_wdata(req_wdata), .req_end(req_end), .req_pending(req_pending),
    .req_ovf(req_ovf), .m_awaddr(m_awaddr), .m_wdata(m_wdata), .m_valid(m_valid),
    .m_end(m_end), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            id;
  } wr_t;

  typedef struct {
    logic [1:0]    valid;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    int            first;
  } vec_t;

  wr_t exp_q[$];
  int  end_q[$];
  int  tests = 0;
  int  fails = 0;
  bit  auto_resp = 1'b0;
  int  resp_lat = 1;
  wr_t mon_e;
  int  mon_id;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int id);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.id   = id;
    exp_q.push_back(w);
  endtask

  task automatic set_req(input logic [1:0] v, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req_valid  = v;
    req_awaddr = {a1, a0};
    req_wdata  = {d1, d0};
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || end_q.size() != 0 || req_pending != '0) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk({name, " drain"}, 64'(c < 200), 64'd1);
  endtask

  task automatic wait_end(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (req_end != '0) seen = 1'b1;
    end
  endtask

  // Lite master model: completes each write resp_lat cycles after m_valid.
  initial begin
    resp_end = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_resp && m_valid && rst_n) begin
        repeat (resp_lat) @(posedge clk);
        #1 resp_end = 1'b1;
        @(posedge clk);
        #1 resp_end = 1'b0;
      end
    end
  end

  // Scoreboard: each m_valid pops an expected write; each req_end pops its owner.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid) begin
        if (exp_q.size() == 0) chk("unexpected m_valid", 64'd1, 64'd0);
        else begin
          mon_e = exp_q.pop_front();
          chk("m_awaddr", 64'(m_awaddr), 64'(mon_e.addr));
          chk("m_wdata", 64'(m_wdata), 64'(mon_e.data));
          chk("grant_id", 64'(grant_id), 64'(mon_e.id));
          end_q.push_back(mon_e.id);
        end
      end
      if (req_end != '0) begin
        if (end_q.size() == 0) chk("unexpected req_end", 64'(req_end), 64'd0);
        else begin
          mon_id = end_q.pop_front();
          chk("req_end owner", 64'(req_end), 64'(1) << mon_id);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    vec_t tbl [7];
    int   model_last, f, o, id, exp_id, bad;
    bit   seen;

    tbl[0] = '{2'b11, AW'(REG_DA),    32'h0000_0000, AW'(REG_DA),     32'h0000_0000, 0};
    tbl[1] = '{2'b01, AW'(REG_DMACR), 32'h0001_1003, AW'(0),          32'h0,         0};
    tbl[2] = '{2'b11, AW'(REG_DMASR), 32'hFFFF_FFFF, AW'(REG_MSB),    32'h1234_5678, 1};
    tbl[3] = '{2'b10, AW'(0),         32'h0,         10'h3FF,         32'hA5A5_A5A5, 1};
    tbl[4] = '{2'b11, 10'h000,        32'hDEAD_BEEF, AW'(REG_LENGTH), 32'h0000_0100, 0};
    tbl[5] = '{2'b01, AW'(REG_MSB),   32'h0000_0001, AW'(0),          32'h0,         0};
    tbl[6] = '{2'b01, AW'(REG_DA),    32'h8000_0000, AW'(0),          32'h0,         0};

    rst_n = 1'b0;
    man_end = 1'b0;
    set_req(2'b00, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset m_valid", 64'(m_valid), 64'd0);
    chk("reset req_pending", 64'(req_pending), 64'd0);
    chk("reset req_ovf", 64'(req_ovf), 64'd0);
    chk("reset req_end", 64'(req_end), 64'd0);
    chk("reset grant_id", 64'(grant_id), 64'd0);
    chk("reset m_awaddr", 64'(m_awaddr), 64'd0);
    chk("reset timeout_err", 64'(timeout_err), 64'd0);

    // Vector table; row 0 is the simultaneous request straight after reset.
    auto_resp = 1'b1;
    resp_lat  = 1;
    model_last = 1;
    for (int r = 0; r < 7; r++) begin
      if (tbl[r].valid == 2'b11) begin
        f = tbl[r].first;
        o = 1 - f;
        push_wr(f == 0 ? tbl[r].a0 : tbl[r].a1, f == 0 ? tbl[r].d0 : tbl[r].d1, f);
        push_wr(o == 0 ? tbl[r].a0 : tbl[r].a1, o == 0 ? tbl[r].d0 : tbl[r].d1, o);
        model_last = o;
      end else begin
        id = tbl[r].valid[1] ? 1 : 0;
        push_wr(id == 0 ? tbl[r].a0 : tbl[r].a1, id == 0 ? tbl[r].d0 : tbl[r].d1, id);
        model_last = id;
      end
      @(posedge clk);
      #1 set_req(tbl[r].valid, tbl[r].a0, tbl[r].d0, tbl[r].a1, tbl[r].d1);
      @(posedge clk);
      #1 req_valid = '0;
      drain($sformatf("vec%0d", r));
      chk($sformatf("vec%0d ovf", r), 64'(req_ovf), 64'd0);
    end

    // Single request, hand-timed latency.
    auto_resp = 1'b0;
    push_wr(AW'(REG_DMACR), 32'h0001_1003, 0);
    @(posedge clk);
    #1 set_req(2'b01, AW'(REG_DMACR), 32'h0001_1003, '0, '0);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("single m_valid T+1", 64'(m_valid), 64'd0);
    chk("single pending T+1", 64'(req_pending), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("single m_valid T+2", 64'(m_valid), 64'd1);
    chk("single m_awaddr T+2", 64'(m_awaddr), 64'h30);
    chk("single m_wdata T+2", 64'(m_wdata), 64'h0001_1003);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("single m_valid T+3", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 man_end = 1'b1;
    @(posedge clk);
    #1 man_end = 1'b0;
    @(negedge clk);
    chk("single req_end T+6", 64'(req_end), 64'd1);
    chk("single pending T+6", 64'(req_pending), 64'd1);
    chk("single m_awaddr held", 64'(m_awaddr), 64'h30);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("single pending T+7", 64'(req_pending), 64'd0);
    chk("single req_end T+7", 64'(req_end), 64'd0);
    model_last = 0;

    // Overflow: second request on a pending slot is dropped.
    auto_resp = 1'b1;
    resp_lat  = 3;
    push_wr(AW'(REG_LENGTH), 32'h0000_0400, 1);
    @(posedge clk);
    #1 set_req(2'b10, '0, '0, AW'(REG_LENGTH), 32'h0000_0400);
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    #1 set_req(2'b10, '0, '0, AW'(REG_DMASR), 32'hBAD0_BAD0);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("ovf flag", 64'(req_ovf), 64'h2);
    drain("ovf");
    chk("ovf sticky", 64'(req_ovf), 64'h2);
    resp_lat = 1;
    model_last = 1;

    // Set-wins: re-request in the completion cycle keeps the slot pending.
    push_wr(AW'(REG_DA), 32'h1000_0000, 0);
    @(posedge clk);
    #1 set_req(2'b01, AW'(REG_DA), 32'h1000_0000, '0, '0);
    @(posedge clk);
    #1 req_valid = '0;
    wait_end(seen);
    chk("setwins end seen", 64'(seen), 64'd1);
    push_wr(AW'(REG_MSB), 32'h0000_0001, 0);
    set_req(2'b01, AW'(REG_MSB), 32'h0000_0001, '0, '0);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("setwins pending", 64'(req_pending), 64'd1);
    drain("setwins");
    chk("setwins ovf", 64'(req_ovf), 64'h2);
    model_last = 0;

    // Fairness: both requesters re-request on every completion.
    f = (model_last == 0) ? 1 : 0;
    o = 1 - f;
    push_wr(AW'(REG_DA), 32'h0000_0F00, f);
    push_wr(AW'(REG_DA), 32'h0000_0F01, o);
    @(posedge clk);
    #1 set_req(2'b11, AW'(REG_DA), (f == 0) ? 32'h0F00 : 32'h0F01,
               AW'(REG_DA), (f == 1) ? 32'h0F00 : 32'h0F01);
    @(posedge clk);
    #1 req_valid = '0;
    for (int k = 2; k < 8; k++) begin
      wait_end(seen);
      chk($sformatf("fair end seen %0d", k), 64'(seen), 64'd1);
      id = req_end[1] ? 1 : 0;
      exp_id = ((k % 2) == 0) ? f : o;
      chk($sformatf("fair owner %0d", k), 64'(id), 64'(exp_id));
      push_wr(AW'(REG_DA), 32'h0000_0F00 + 32'(k), id);
      set_req(2'b01 << id, AW'(REG_DA), 32'h0000_0F00 + 32'(k), AW'(REG_DA), 32'h0000_0F00 + 32'(k));
      @(posedge clk);
      #1 req_valid = '0;
    end
    drain("fair");

    // Reset while waiting on the master drops the write.
    auto_resp = 1'b0;
    push_wr(AW'(REG_DMACR), 32'h0000_0004, 0);
    @(posedge clk);
    #1 set_req(2'b01, AW'(REG_DMACR), 32'h0000_0004, '0, '0);
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    end_q.delete();
    @(negedge clk);
    chk("rst m_valid", 64'(m_valid), 64'd0);
    chk("rst pending", 64'(req_pending), 64'd0);
    chk("rst ovf", 64'(req_ovf), 64'd0);
    chk("rst grant_id", 64'(grant_id), 64'd0);
    man_end = 1'b1;
    @(posedge clk);
    #1 man_end = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (req_end != '0 || m_valid) bad++;
    end
    chk("rst stray m_end ignored", 64'(bad), 64'd0);

    auto_resp = 1'b1;
    push_wr(AW'(REG_DMASR), 32'h0000_0001, 1);
    @(posedge clk);
    #1 set_req(2'b10, '0, '0, AW'(REG_DMASR), 32'h0000_0001);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("post-rst m_valid T+1", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post-rst m_valid T+2", 64'(m_valid), 64'd1);
    drain("post-rst");

`ifdef LITE_ARB_TIMEOUT_EN
    auto_resp = 1'b0;
    push_wr(AW'(REG_LENGTH), 32'h0000_0010, 0);
    @(posedge clk);
    #1 set_req(2'b01, AW'(REG_LENGTH), 32'h0000_0010, '0, '0);
    @(posedge clk);
    #1 req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    chk("tmo m_valid seen", 64'(seen), 64'd1);
    bad = 0;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (req_end != '0) begin
        seen = 1'b1;
        bad = c;
      end
    end
    chk("tmo req_end delay", 64'(bad), 64'd17);
    chk("tmo timeout_err", 64'(timeout_err), 64'd1);
    drain("tmo");
`else
    chk("timeout_err tied low", 64'(timeout_err), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lite_cfg_arbiter.md
Name: lite_cfg_arbiter

Overview:
- Shares one AXI-Lite register-write master between N_REQ DMA channel sequencers, e.g. the MM2S and S2MM register-programming controllers.
- Each requester issues single-cycle write pulses carrying an address and data word.
- The arbiter captures each pulse, grants the master round-robin, forwards one write at a time, and returns the master's completion pulse to the owning requester.

Parameters:
N_REQ, 2, number of requesters (2..8)
ADDR_W, 10, register address width
DATA_W, 32, write data width
TIMEOUT_CYCLES, 1023, WAIT-state cycle limit (used only with LITE_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req_valid  in  N_REQ  one-cycle write request pulse per requester
req_awaddr  in  N_REQ*ADDR_W  packed addresses; slot i = bits [i*ADDR_W +: ADDR_W]
req_wdata  in  N_REQ*DATA_W  packed write data, same packing
req_end  out  N_REQ  one-cycle completion pulse to requester i
req_pending  out  N_REQ  slot i holds an unserviced or in-flight write
req_ovf  out  N_REQ  sticky: req_valid seen while slot already pending
m_awaddr  out  ADDR_W  address to shared lite master
m_wdata  out  DATA_W  data to shared lite master
m_valid  out  1  one-cycle start pulse to lite master
m_end  in  1  one-cycle completion pulse from lite master
grant_id  out  clog2(N_REQ) (min 1)  index of current/last granted requester
timeout_err  out  1  sticky timeout flag (LITE_ARB_TIMEOUT_EN only)

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all outputs, pending slots and sticky flags to 0. RR pointer resets so requester 0 wins first. State = IDLE.
- Reset mid-operation drops all pending writes; requesters must reissue.
- Capture: req_valid[i]=1 with pending[i]=0 latches addr/data into slot i and sets pending[i] next cycle.
  - If pending[i]=1, the new request is ignored, the slot is unchanged, and req_ovf[i] is set.
  - Exception: in the cycle pending[i] clears on completion, a coincident req_valid[i] is captured and pending[i] stays 1; set wins.
- FSM, one-hot states IDLE, ISSUE, WAIT, DONE:
  - IDLE: if any pending, choose the first pending index strictly after last grant, wrapping. Register grant_id, m_awaddr and m_wdata from that slot, then go to ISSUE.
  - ISSUE: m_valid=1 for exactly this cycle, then go to WAIT.
  - WAIT: m_awaddr/m_wdata held stable. On m_end go to DONE; m_end outside WAIT is ignored.
  - DONE: req_end[grant_id]=1 for one cycle, pending[grant_id] cleared, RR pointer updated to grant_id, then go to IDLE.
- Latency: req_valid at cycle T with the arbiter idle gives m_valid at T+2. m_end at cycle U gives req_end at U+1. Next grant can be taken at U+2, so next m_valid is at U+3 at the earliest.
- m_awaddr/m_wdata keep their last value in IDLE; they are not zeroed.
- Only one write is ever outstanding on the master.

Optional Feature:
- Macro LITE_ARB_TIMEOUT_EN.
- Defined: a counter runs in WAIT. If it reaches TIMEOUT_CYCLES without m_end:
  - go to DONE and pulse req_end normally;
  - set sticky timeout_err;
  - clear the counter on each ISSUE.
- Undefined: no counter; WAIT waits indefinitely; timeout_err is tied to 0.

Decomposition:
- Package lite_arb_pkg holds:
  - state one-hot encodings (IDLE=4'b0001, ISSUE=4'b0010, WAIT=4'b0100, DONE=4'b1000);
  - the grant-width function;
  - shared DMA register offsets (DMACR 0x30, DMASR 0x34, DA 0x48, MSB 0x4C, LENGTH 0x58) for benches.
- Sub-module rr_pick: combinational round-robin selector with inputs pending vector and last grant, outputs index and any-flag.

Test Plan:
- Single request: req_valid[0] with addr 0x30, data 0x00011003 at T → m_valid at T+2 with those values; m_end at T+5 → req_end[0] at T+6; pending[0] low at T+7.
- Simultaneous: req_valid=2'b11 (addr 0x48, 0x00) after reset → req 0 served first, then req 1; two m_valid pulses, req_end order 0 then 1.
- Fairness: both requesters re-request immediately on each req_end for 8 writes → grants alternate 0,1,0,1; no starvation.
- Overflow: req_valid[1] twice before its completion → second ignored, req_ovf[1]=1, original data 0x58/LENGTH written.
- Set-wins: req_valid[0] in the same cycle pending[0] clears → pending[0] stays 1 and a second write is issued.
- Reset in WAIT: rst_n low for 1 cycle → m_valid=0, pending=0, state IDLE; a later m_end produces no req_end. With LITE_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16 and no m_end → req_end after 16 WAIT cycles and timeout_err=1.
